// File: rtl/i2s_clkgen_pkg.sv
// Shared I2S clock-generator constants: channel-length encodings and divider width.
package i2s_clkgen_pkg;

    localparam int I2S_DIV_WIDTH = 16;

    localparam logic [1:0] I2S_DAT_8_BITS  = 2'd0;
    localparam logic [1:0] I2S_DAT_16_BITS = 2'd1;
    localparam logic [1:0] I2S_DAT_24_BITS = 2'd2;
    localparam logic [1:0] I2S_DAT_32_BITS = 2'd3;

    // Index of the last bit in a channel: 8*(chl+1)-1.
    function automatic logic [4:0] last_bit(input logic [1:0] chl);
        return {chl, 3'b111};
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Free-running prescaler: counts 0..max_i and pulses tick_o on the terminal count.
module clk_div_tick #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] max_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt;

    assign tick_o = en_i && (cnt == max_i);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= tick_o ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_clkgen.sv
// Master-mode I2S SCK/WS generator with system-clock-domain edge and frame strobes.
module i2s_clkgen
    import i2s_clkgen_pkg::*;
#(
    parameter int DIV_WIDTH = I2S_DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           chl_i,
    output logic                 sck_o,
    output logic                 ws_o,
    output logic                 sck_re_o,
    output logic                 sck_fe_o,
    output logic                 frame_o,
    output logic                 busy_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_q;
    logic [1:0]           chl_q;
    logic [4:0]           bcnt;
    logic                 run;
    logic                 tick;

    // Dropping en_i clears the divider on the same edge the FSM leaves RUN.
    assign run = (state == RUN) && en_i;

    clk_div_tick #(
        .WIDTH (DIV_WIDTH)
    ) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (run),
        .clr_i  (~run),
        .max_i  (div_q),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            div_q    <= '0;
            chl_q    <= '0;
            bcnt     <= '0;
            sck_o    <= 1'b0;
            ws_o     <= 1'b0;
            sck_re_o <= 1'b0;
            sck_fe_o <= 1'b0;
            frame_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        div_q  <= div_i;
                        chl_q  <= chl_i;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state    <= IDLE;
                        bcnt     <= '0;
                        sck_o    <= 1'b0;
                        ws_o     <= 1'b0;
                        sck_re_o <= 1'b0;
                        sck_fe_o <= 1'b0;
                        frame_o  <= 1'b0;
                        busy_o   <= 1'b0;
                    end else begin
                        sck_re_o <= tick & ~sck_o;
                        sck_fe_o <= tick & sck_o;
                        frame_o  <= 1'b0;
                        if (tick) begin
                            sck_o <= ~sck_o;
                        end
                        // WS flips on the falling edge one bit ahead of the next channel's MSB.
                        if (tick && sck_o) begin
                            if (bcnt == last_bit(chl_q)) begin
                                bcnt <= '0;
                                ws_o <= ~ws_o;
                                if (ws_o) begin
                                    frame_o <= 1'b1;
                                    div_q   <= div_i;
                                    chl_q   <= chl_i;
                                end
                            end else begin
                                bcnt <= bcnt + 5'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_clkgen.sv
// Self-checking bench for i2s_clkgen: elapsed-time reference model plus directed period checks.
module tb_i2s_clkgen;
    import i2s_clkgen_pkg::*;

    localparam int DW = I2S_DIV_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [DW-1:0] div = '0;
    logic [1:0]    chl = '0;
    logic          sck, ws, sck_re, sck_fe, frame, busy;
    logic [5:0]    dut_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    i2s_clkgen #(.DIV_WIDTH(DW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .div_i    (div),
        .chl_i    (chl),
        .sck_o    (sck),
        .ws_o     (ws),
        .sck_re_o (sck_re),
        .sck_fe_o (sck_fe),
        .frame_o  (frame),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out = {sck, ws, sck_re, sck_fe, frame, busy};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outputs derived from the cycle count k since the current frame began,
    // the half period h and channel length len. Output order {sck,ws,re,fe,frame,busy}.
    typedef struct packed {
        logic       run;
        int         k;
        int         h;
        int         len;
        logic [5:0] out;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t step(mstate_t s, logic e, logic [DW-1:0] d, logic [1:0] c);
        mstate_t o;
        int n, r, f;
        o = s;
        if (!s.run) begin
            o.out = '0;
            if (e) begin
                o.run = 1'b1;
                o.k   = 0;
                o.h   = int'(d) + 1;
                o.len = 8 * (int'(c) + 1);
                o.out = 6'b000001;
            end
        end else if (!e) begin
            o.run = 1'b0;
            o.out = '0;
        end else begin
            o.k = s.k + 1;
            n = o.k / s.h;
            r = o.k % s.h;
            f = n / 2;
            if (r == 0 && n % 2 == 0 && f == 2 * s.len) begin
                o.out = 6'b000111;
                o.k   = 0;
                o.h   = int'(d) + 1;
                o.len = 8 * (int'(c) + 1);
            end else begin
                o.out = {n % 2 == 1, f >= s.len, r == 0 && n % 2 == 1, r == 0 && n % 2 == 0,
                         1'b0, 1'b1};
            end
        end
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= '0;
        else     ms <= step(ms, en, div, chl);
    end

    always @(negedge clk) check("model", {58'd0, dut_out}, {58'd0, ms.out});

    // sel: 0 = sck_re, 1 = frame, 2 = sck_fe. Returns the cycle number, or -1 on timeout.
    task automatic wait_sig(input int sel, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            case (sel)
                0:       s = sck_re;
                1:       s = frame;
                default: s = sck_fe;
            endcase
            if (s === 1'b1) begin
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout waiting for strobe %0d @cyc %0d", sel, cyc);
    endtask

    task automatic go_idle();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [DW-1:0] div;
        logic [1:0]    chl;
        int            sck_per;
        int            frame_per;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c0, t1, t2, t3, t4, f1, f2;
        logic prev_ws;

        vecs[0] = '{16'd0, I2S_DAT_8_BITS,  2,  32};
        vecs[1] = '{16'd3, I2S_DAT_32_BITS, 8,  512};
        vecs[2] = '{16'd1, I2S_DAT_16_BITS, 4,  128};
        vecs[3] = '{16'd4, I2S_DAT_24_BITS, 10, 480};
        vecs[4] = '{16'd2, I2S_DAT_8_BITS,  6,  96};
        vecs[5] = '{16'd0, I2S_DAT_32_BITS, 2,  128};

        // Reset with enable high and a random divider
        #1;
        rst = 1'b1;
        en  = 1'b1;
        div = DW'($urandom_range(0, 200));
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {58'd0, dut_out}, 64'd0);
        end
        #2 rst = 1'b0;
        #1 check("post_reset_idle", {58'd0, dut_out}, 64'd0);
        @(negedge clk);
        check("post_reset_busy", {63'd0, busy}, 64'd1);
        go_idle();

        // Table-driven period measurements
        for (int i = 0; i < 6; i++) begin
            go_idle();
            div = vecs[i].div;
            chl = vecs[i].chl;
            en  = 1'b1;
            @(negedge clk);
            c0 = cyc;
            wait_sig(0, t1);
            check("first_rise", 64'(t1 - c0), 64'(vecs[i].sck_per / 2));
            check("first_ws", {63'd0, ws}, 64'd0);
            wait_sig(0, t2);
            check("sck_period", 64'(t2 - t1), 64'(vecs[i].sck_per));
            wait_sig(1, f1);
            check("first_frame", 64'(f1 - c0), 64'(vecs[i].frame_per));
            wait_sig(1, f2);
            check("frame_period", 64'(f2 - f1), 64'(vecs[i].frame_per));
        end

        // WS may only toggle together with a falling-edge strobe
        go_idle();
        div = 16'd3;
        chl = I2S_DAT_32_BITS;
        en  = 1'b1;
        @(negedge clk);
        prev_ws = ws;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (ws !== prev_ws) check("ws_on_fe", {63'd0, sck_fe}, 64'd1);
            prev_ws = ws;
        end

        // Settings changed mid-frame take effect only after the frame boundary
        go_idle();
        div = 16'd1;
        chl = I2S_DAT_16_BITS;
        en  = 1'b1;
        @(negedge clk);
        c0 = cyc;
        repeat (40) @(negedge clk);
        div = 16'd4;
        chl = I2S_DAT_24_BITS;
        wait_sig(0, t1);
        wait_sig(0, t2);
        check("old_period", 64'(t2 - t1), 64'd4);
        wait_sig(1, f1);
        check("old_frame_len", 64'(f1 - c0), 64'd128);
        wait_sig(0, t3);
        check("new_first_rise", 64'(t3 - f1), 64'd5);
        wait_sig(0, t4);
        check("new_period", 64'(t4 - t3), 64'd10);
        wait_sig(1, f2);
        check("new_frame_len", 64'(f2 - f1), 64'd480);

        // Drop enable in the right channel, then restart
        go_idle();
        div = 16'd2;
        chl = I2S_DAT_8_BITS;
        en  = 1'b1;
        for (int i = 0; i < 200 && ws !== 1'b1; i++) @(negedge clk);
        check("reached_right", {63'd0, ws}, 64'd1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("drop_clear", {58'd0, dut_out}, 64'd0);
        en = 1'b1;
        @(negedge clk);
        c0 = cyc;
        wait_sig(0, t1);
        check("restart_rise", 64'(t1 - c0), 64'd3);
        check("restart_ws", {63'd0, ws}, 64'd0);

        // One-cycle asynchronous reset pulse mid-frame
        go_idle();
        div = 16'd1;
        chl = I2S_DAT_8_BITS;
        en  = 1'b1;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", {58'd0, dut_out}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_wait_en", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("rst_resume", {63'd0, busy}, 64'd1);

        // Randomized run: model checks every cycle
        for (int rnd = 0; rnd < 20; rnd++) begin
            go_idle();
            div = DW'($urandom_range(0, 5));
            chl = 2'($urandom_range(0, 3));
            en  = 1'b1;
            for (int j = 0; j < int'($urandom_range(100, 1500)); j++) begin
                @(negedge clk);
                if ($urandom_range(0, 19) == 0) begin
                    div = DW'($urandom_range(0, 5));
                    chl = 2'($urandom_range(0, 3));
                end
                en = ($urandom_range(0, 299) != 0);
            end
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
